// File: rtl/planar_route_scheduler_if.sv
// Request/valve bundle between the route scheduler and its controller.
// The master modport belongs to the controller side; the slave modport belongs to the scheduler.
interface planar_route_scheduler_if #(
  parameter int N_SW    = 6,
  parameter int TGT_W   = 4,
  parameter int DWELL_W = 16
);
  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [2*TGT_W-1:0]   req_target;
  logic [2*DWELL_W-1:0] req_dwell;
  logic [1:0]           abort;
  logic [1:0]           done;
  logic [1:0]           aborted;
  logic [1:0]           err;
  logic [1:0]           busy;
  logic [4*N_SW-1:0]    sw_cfg;
  logic [1:0]           mrg_sel;

  modport master (
    output req_valid, req_target, req_dwell, abort,
    input  req_ready, done, aborted, err, busy, sw_cfg, mrg_sel
  );

  modport slave (
    input  req_valid, req_target, req_dwell, abort,
    output req_ready, done, aborted, err, busy, sw_cfg, mrg_sel
  );
endinterface

// File: rtl/planar_route_scheduler.sv
// Two-lane planar flow-switch sequencer. Each lane primes, holds and flushes its
// switch chain; the shared merge valve is handed out round-robin to output-path routes.
module planar_route_scheduler #(
  parameter int N_SW       = 6,
  parameter int TGT_W      = 4,
  parameter int DWELL_W    = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  planar_route_scheduler_if.slave bus
);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int CNT_W = (DWELL_W > SET_W) ? DWELL_W : SET_W;
  localparam logic [TGT_W-1:0]  OUT_TGT   = TGT_W'(2 * N_SW);
  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [2*N_SW-1:0] ALL_PASS  = {N_SW{2'b01}};

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_MRG, S_PRIME, S_FLOW, S_FLUSH
  } lane_state_t;

  // Upstream switches pass, the selected switch diverts, downstream stays closed.
  function automatic logic [2*N_SW-1:0] decode_branch(input logic [TGT_W-1:0] t);
    logic [2*N_SW-1:0] cfg;
    int sel;
    cfg = '0;
    sel = int'(t >> 1);
    for (int k = 0; k < N_SW; k++) begin
      if (k < sel) begin
        cfg[2*k +: 2] = 2'b01;
      end else if (k == sel) begin
        cfg[2*k +: 2] = {1'b1, t[0]};
      end
    end
    return cfg;
  endfunction

  logic [1:0]        waiting;
  logic [1:0]        grant;
  logic [1:0]        release_req;
  logic [1:0]        close_req;
  logic [1:0]        lane_busy;
  logic [1:0]        lane_done;
  logic [1:0]        lane_aborted;
  logic [1:0]        lane_err;
  logic [4*N_SW-1:0] cfg_all;

  logic       owner_valid_reg;
  logic       owner_reg;
  logic       rr_ptr_reg;
  logic [1:0] mrg_sel_reg;

  // Grants only when nobody owns the merge; a tie goes to the lane after the pointer.
  always_comb begin
    grant = 2'b00;
    if (!owner_valid_reg) begin
      if (waiting == 2'b11) begin
        grant = rr_ptr_reg ? 2'b01 : 2'b10;
      end else begin
        grant = waiting;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_valid_reg <= 1'b0;
      owner_reg       <= 1'b0;
      rr_ptr_reg      <= 1'b1;
      mrg_sel_reg     <= 2'b00;
    end else begin
      if (owner_valid_reg && release_req[owner_reg]) begin
        owner_valid_reg <= 1'b0;
      end
      if (owner_valid_reg && close_req[owner_reg]) begin
        mrg_sel_reg <= 2'b00;
      end
      // A grant is one-hot and doubles as the merge valve code.
      if (grant != 2'b00) begin
        owner_valid_reg <= 1'b1;
        owner_reg       <= grant[1];
        rr_ptr_reg      <= grant[1];
        mrg_sel_reg     <= grant;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      lane_state_t       state_reg;
      logic [CNT_W-1:0]  cnt_reg;
      logic [DWELL_W-1:0] dwell_reg;
      logic [2*N_SW-1:0] cfg_reg;
      logic              abort_seen_reg;
      logic              done_reg;
      logic              aborted_reg;
      logic              err_reg;
      logic [TGT_W-1:0]  tgt;
      logic [DWELL_W-1:0] dwell_in;
      logic              cnt_last;
      logic              lane_abort;

      assign tgt        = bus.req_target[gi*TGT_W +: TGT_W];
      assign dwell_in   = bus.req_dwell[gi*DWELL_W +: DWELL_W];
      assign lane_abort = bus.abort[gi];
      assign cnt_last   = (cnt_reg == CNT_ONE);

      assign waiting[gi]     = (state_reg == S_WAIT_MRG) && !lane_abort;
      assign release_req[gi] = (state_reg == S_FLUSH) && cnt_last;
      assign close_req[gi]   = ((state_reg == S_PRIME) && lane_abort) ||
                               ((state_reg == S_FLOW) && (lane_abort || cnt_last));

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg      <= S_IDLE;
          cnt_reg        <= '0;
          dwell_reg      <= '0;
          cfg_reg        <= '0;
          abort_seen_reg <= 1'b0;
          done_reg       <= 1'b0;
          aborted_reg    <= 1'b0;
          err_reg        <= 1'b0;
        end else begin
          done_reg    <= 1'b0;
          aborted_reg <= 1'b0;
          err_reg     <= 1'b0;
          case (state_reg)
            S_IDLE: begin
              if (bus.req_valid[gi]) begin
                dwell_reg      <= (dwell_in == '0) ? DWELL_W'(1) : dwell_in;
                abort_seen_reg <= 1'b0;
                if (tgt < OUT_TGT) begin
                  state_reg <= S_PRIME;
                  cnt_reg   <= SETTLE_LD;
                  cfg_reg   <= decode_branch(tgt);
                end else if (tgt == OUT_TGT) begin
                  state_reg <= S_WAIT_MRG;
                end else begin
                  err_reg <= 1'b1;
                end
              end
            end
            S_WAIT_MRG: begin
              // Abort beats a same-cycle grant; the arbiter already excludes this lane.
              if (lane_abort) begin
                state_reg   <= S_IDLE;
                done_reg    <= 1'b1;
                aborted_reg <= 1'b1;
              end else if (grant[gi]) begin
                state_reg <= S_PRIME;
                cnt_reg   <= SETTLE_LD;
                cfg_reg   <= ALL_PASS;
              end
            end
            S_PRIME: begin
              if (lane_abort) begin
                state_reg      <= S_FLUSH;
                cnt_reg        <= SETTLE_LD;
                cfg_reg        <= '0;
                abort_seen_reg <= 1'b1;
              end else if (cnt_last) begin
                state_reg <= S_FLOW;
                cnt_reg   <= CNT_W'(dwell_reg);
              end else begin
                cnt_reg <= cnt_reg - CNT_ONE;
              end
            end
            S_FLOW: begin
              if (lane_abort || cnt_last) begin
                state_reg      <= S_FLUSH;
                cnt_reg        <= SETTLE_LD;
                cfg_reg        <= '0;
                abort_seen_reg <= lane_abort;
              end else begin
                cnt_reg <= cnt_reg - CNT_ONE;
              end
            end
            S_FLUSH: begin
              if (cnt_last) begin
                state_reg   <= S_IDLE;
                done_reg    <= 1'b1;
                aborted_reg <= abort_seen_reg;
              end else begin
                cnt_reg <= cnt_reg - CNT_ONE;
              end
            end
            default: begin
              state_reg <= S_IDLE;
              cfg_reg   <= '0;
            end
          endcase
        end
      end

      assign lane_busy[gi]    = (state_reg != S_IDLE);
      assign lane_done[gi]    = done_reg;
      assign lane_aborted[gi] = aborted_reg;
      assign lane_err[gi]     = err_reg;
      assign cfg_all[gi*2*N_SW +: 2*N_SW] = cfg_reg;
    end
  endgenerate

  assign bus.req_ready = ~lane_busy;
  assign bus.busy      = lane_busy;
  assign bus.done      = lane_done;
  assign bus.aborted   = lane_aborted;
  assign bus.err       = lane_err;
  assign bus.sw_cfg    = cfg_all;
  assign bus.mrg_sel   = mrg_sel_reg;
endmodule

// File: tb/tb_planar_route_scheduler.sv
// Self-checking bench for planar_route_scheduler: directed scenarios plus random
// two-lane traffic checked cycle by cycle against a timeline model of each route.
module tb_planar_route_scheduler;
  localparam int N_SW    = 6;
  localparam int TGT_W   = 4;
  localparam int DWELL_W = 16;
  localparam int S       = 4;
  localparam int OUT_T   = 2 * N_SW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  planar_route_scheduler_if #(.N_SW(N_SW), .TGT_W(TGT_W), .DWELL_W(DWELL_W)) bus ();

  planar_route_scheduler #(
    .N_SW(N_SW), .TGT_W(TGT_W), .DWELL_W(DWELL_W), .SETTLE_CYC(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors  = 0;
  int checks  = 0;
  int rr_last = 1;  // lane granted most recently; reset makes lane0 win the first tie

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Valve codes a lane should show while its route is open.
  function automatic logic [2*N_SW-1:0] lane_cfg(input int t);
    logic [2*N_SW-1:0] c;
    int code;
    c = '0;
    for (int k = 0; k < N_SW; k++) begin
      if (t == OUT_T)       code = 1;
      else if (k < t / 2)   code = 1;
      else if (k == t / 2)  code = 2 + (t % 2);
      else                  code = 0;
      c[2*k +: 2] = 2'(code);
    end
    return c;
  endfunction

  // Route opened at cycle ps: S prime + dm flow cycles unless aborted first, then S flush.
  function automatic void sched(input int ps, input int dm, input int ab_at,
                                output int fs, output int dn, output bit abd);
    if (ab_at >= ps && ab_at < ps + S + dm) begin
      fs  = ab_at + 1;
      abd = 1'b1;
    end else begin
      fs  = ps + S + dm;
      abd = 1'b0;
    end
    dn = fs + S;
  endfunction

  task automatic run_scenario(input logic [1:0] vmask, input int t0, input int t1,
                              input int d0, input int d1, input int ab_lane, input int ab_cyc,
                              output int obs_done0, output int obs_done1,
                              output logic [4*N_SW-1:0] cfg_c1);
    int t[2], dm[2], ps[2], fs[2], dn[2], ab_at[2];
    bit legal[2], isout[2], abd[2];
    int first, second, last, nout;
    logic [4*N_SW-1:0] e_cfg;
    logic [1:0] e_mrg, e_done, e_ab, e_busy, e_err;

    t[0] = t0;  t[1] = t1;
    dm[0] = (d0 == 0) ? 1 : d0;
    dm[1] = (d1 == 0) ? 1 : d1;
    nout = 0;
    for (int l = 0; l < 2; l++) begin
      legal[l] = vmask[l] && (t[l] <= OUT_T);
      isout[l] = legal[l] && (t[l] == OUT_T);
      ab_at[l] = (ab_lane == l) ? ab_cyc : -1;
      ps[l] = 0; fs[l] = 0; dn[l] = 0; abd[l] = 1'b0;
      if (isout[l]) nout++;
      if (legal[l] && !isout[l]) begin
        ps[l] = 1;
        sched(ps[l], dm[l], ab_at[l], fs[l], dn[l], abd[l]);
      end
    end
    if (nout == 2) begin
      first  = 1 - rr_last;
      second = 1 - first;
      ps[first] = 2;
      sched(ps[first], dm[first], ab_at[first], fs[first], dn[first], abd[first]);
      rr_last = first;
      if (ab_at[second] >= 1 && ab_at[second] <= dn[first]) begin
        dn[second]  = ab_at[second] + 1;
        abd[second] = 1'b1;
      end else begin
        ps[second] = dn[first] + 1;
        sched(ps[second], dm[second], ab_at[second], fs[second], dn[second], abd[second]);
        rr_last = second;
      end
    end else if (nout == 1) begin
      first = isout[0] ? 0 : 1;
      ps[first] = 2;
      sched(ps[first], dm[first], ab_at[first], fs[first], dn[first], abd[first]);
      rr_last = first;
    end
    last = 2;
    for (int l = 0; l < 2; l++) if (dn[l] > last) last = dn[l];

    bus.req_valid  = vmask;
    bus.req_target = {TGT_W'(t1), TGT_W'(t0)};
    bus.req_dwell  = {DWELL_W'(d1), DWELL_W'(d0)};
    obs_done0 = -1;
    obs_done1 = -1;
    cfg_c1 = '0;

    for (int c = 1; c <= last; c++) begin
      step();
      if (c == 1) begin
        bus.req_valid = 2'b00;
        cfg_c1 = bus.sw_cfg;
      end
      e_cfg = '0; e_mrg = '0; e_done = '0; e_ab = '0; e_busy = '0; e_err = '0;
      for (int l = 0; l < 2; l++) begin
        if (legal[l] && c >= ps[l] && c < fs[l]) begin
          e_cfg[l*2*N_SW +: 2*N_SW] = lane_cfg(t[l]);
          if (isout[l]) e_mrg[l] = 1'b1;
        end
        if (legal[l] && c == dn[l]) begin
          e_done[l] = 1'b1;
          e_ab[l]   = abd[l];
        end
        if (legal[l] && c < dn[l]) e_busy[l] = 1'b1;
        if (vmask[l] && !legal[l] && c == 1) e_err[l] = 1'b1;
      end
      if (bus.done[0] && obs_done0 < 0) obs_done0 = c;
      if (bus.done[1] && obs_done1 < 0) obs_done1 = c;

      checks++;
      if (bus.sw_cfg !== e_cfg) begin
        errors++;
        $display("FAIL sw_cfg cyc=%0d got=%h exp=%h", c, bus.sw_cfg, e_cfg);
      end
      checks++;
      if (bus.mrg_sel !== e_mrg) begin
        errors++;
        $display("FAIL mrg_sel cyc=%0d got=%b exp=%b", c, bus.mrg_sel, e_mrg);
      end
      checks++;
      if (bus.done !== e_done) begin
        errors++;
        $display("FAIL done cyc=%0d got=%b exp=%b", c, bus.done, e_done);
      end
      checks++;
      if (bus.aborted !== e_ab) begin
        errors++;
        $display("FAIL aborted cyc=%0d got=%b exp=%b", c, bus.aborted, e_ab);
      end
      checks++;
      if (bus.busy !== e_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", c, bus.busy, e_busy);
      end
      checks++;
      if (bus.req_ready !== ~e_busy) begin
        errors++;
        $display("FAIL req_ready cyc=%0d got=%b exp=%b", c, bus.req_ready, ~e_busy);
      end
      checks++;
      if (bus.err !== e_err) begin
        errors++;
        $display("FAIL err cyc=%0d got=%b exp=%b", c, bus.err, e_err);
      end

      bus.abort = 2'b00;
      if (ab_lane >= 0 && c == ab_cyc) bus.abort[ab_lane] = 1'b1;
    end
    bus.abort = 2'b00;
    $display("txn mask=%b t0=%0d t1=%0d d0=%0d d1=%0d abort_lane=%0d abort_cyc=%0d done0@%0d done1@%0d",
             vmask, t0, t1, d0, d1, ab_lane, ab_cyc, obs_done0, obs_done1);
  endtask

  task automatic test_reset();
    bus.req_valid = 2'b00; bus.req_target = '0; bus.req_dwell = '0; bus.abort = 2'b00;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    rr_last = 1;
    step();
    checks++;
    if (bus.sw_cfg !== '0) begin errors++; $display("FAIL reset_sw_cfg got=%h exp=0", bus.sw_cfg); end
    checks++;
    if (bus.mrg_sel !== 2'b00) begin errors++; $display("FAIL reset_mrg_sel got=%b exp=00", bus.mrg_sel); end
    checks++;
    if (bus.req_ready !== 2'b11) begin errors++; $display("FAIL reset_req_ready got=%b exp=11", bus.req_ready); end
    checks++;
    if (bus.busy !== 2'b00) begin errors++; $display("FAIL reset_busy got=%b exp=00", bus.busy); end
    checks++;
    if ({bus.done, bus.aborted, bus.err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_pulses got=%b exp=000000", {bus.done, bus.aborted, bus.err});
    end
    $display("txn reset released");
  endtask

  task automatic test_merge_tie();
    int dn0, dn1;
    logic [4*N_SW-1:0] c1;
    run_scenario(2'b11, OUT_T, OUT_T, 2, 2, -1, 0, dn0, dn1, c1);
    checks++;
    if (dn0 !== 12) begin errors++; $display("FAIL tie_done0 got=%0d exp=12", dn0); end
    checks++;
    if (dn1 !== 23) begin errors++; $display("FAIL tie_done1 got=%0d exp=23", dn1); end
  endtask

  task automatic test_branch();
    int dn0, dn1;
    logic [4*N_SW-1:0] c1;
    run_scenario(2'b01, 5, 0, 3, 0, -1, 0, dn0, dn1, c1);
    checks++;
    if (c1 !== 24'h000035) begin errors++; $display("FAIL branch_cfg got=%h exp=000035", c1); end
    checks++;
    if (dn0 !== 12) begin errors++; $display("FAIL branch_done got=%0d exp=12", dn0); end
  endtask

  task automatic test_abort();
    int dn0, dn1;
    logic [4*N_SW-1:0] c1;
    // abort during the 10th FLOW cycle: FLOW starts at cycle 5, so cycle 14
    run_scenario(2'b10, 0, 0, 0, 100, 1, 14, dn0, dn1, c1);
    checks++;
    if (dn1 !== 19) begin errors++; $display("FAIL abort_done got=%0d exp=19", dn1); end
  endtask

  task automatic test_illegal();
    int dn0, dn1;
    logic [4*N_SW-1:0] c1;
    run_scenario(2'b01, 13, 0, 5, 0, -1, 0, dn0, dn1, c1);
    checks++;
    if (c1 !== '0) begin errors++; $display("FAIL illegal_cfg got=%h exp=0", c1); end
  endtask

  task automatic test_reset_mid_flow();
    int dn0, dn1;
    logic [4*N_SW-1:0] c1;
    bus.req_valid  = 2'b01;
    bus.req_target = {TGT_W'(0), TGT_W'(OUT_T)};
    bus.req_dwell  = {DWELL_W'(0), DWELL_W'(20)};
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) bus.req_valid = 2'b00;
    end
    checks++;
    if (bus.mrg_sel !== 2'b01) begin errors++; $display("FAIL midrst_pre_mrg got=%b exp=01", bus.mrg_sel); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    rr_last = 1;
    checks++;
    if (bus.sw_cfg !== '0) begin errors++; $display("FAIL midrst_sw_cfg got=%h exp=0", bus.sw_cfg); end
    checks++;
    if (bus.mrg_sel !== 2'b00) begin errors++; $display("FAIL midrst_mrg_sel got=%b exp=00", bus.mrg_sel); end
    checks++;
    if (bus.busy !== 2'b00) begin errors++; $display("FAIL midrst_busy got=%b exp=00", bus.busy); end
    checks++;
    if (bus.done !== 2'b00) begin errors++; $display("FAIL midrst_done got=%b exp=00", bus.done); end
    step();
    checks++;
    if (bus.done !== 2'b00) begin errors++; $display("FAIL midrst_done_late got=%b exp=00", bus.done); end
    $display("txn reset during lane0 flow");
    run_scenario(2'b10, 0, OUT_T, 0, 3, -1, 0, dn0, dn1, c1);
    checks++;
    if (dn1 !== 2 + 2 * S + 3) begin errors++; $display("FAIL midrst_regrant_done got=%0d exp=%0d", dn1, 2 + 2 * S + 3); end
  endtask

  task automatic test_random();
    int dn0, dn1, al;
    logic [4*N_SW-1:0] c1;
    for (int i = 0; i < 12; i++) begin
      al = int'($urandom_range(0, 3));
      if (al > 1) al = -1;
      run_scenario(2'($urandom_range(1, 3)),
                   int'($urandom_range(0, 13)), int'($urandom_range(0, 13)),
                   int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                   al, int'($urandom_range(2, 35)), dn0, dn1, c1);
    end
  endtask

  initial begin
    test_reset();
    test_merge_tie();
    test_branch();
    test_abort();
    test_illegal();
    test_reset_mid_flow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
